// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver feeding the Reed-Solomon framing FSM.
// Receives a start bit, DATA_BITS data bits (LSB first), an optional parity
// bit and STOP_BITS stop bits. A start bit that is no longer low at its
// midpoint is rejected as a glitch. The word is delivered with parity and
// framing flags through a valid/ack handshake; an unacknowledged word that
// gets overwritten raises the overrun flag.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY_MODE   0 none, 1 even, 2 odd, 3 space (parity bit must be 0)
//   STOP_BITS     1 or 2
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   Rx_D        serial line, idle high, asynchronous to clk
//   data_ack    consumer accepts data_out (ignored while data_valid = 0)
//   data_out    last received word
//   data_valid  word available, held until acknowledged
//   parity_err  parity check failed for the word in data_out
//   frame_err   a stop bit of that word was sampled low
//   overrun     a word was overwritten before being acknowledged
//   busy        a frame is being received
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 864,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 3,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_D,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_M1 = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_M1 = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CW-1:0]          clk_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   stop_bad;

    // True when the sampled parity bit p is inconsistent with the data word.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        case (PARITY_MODE)
            1:       return x;
            2:       return ~x;
            3:       return p;
            default: return 1'b0;
        endcase
    endfunction

    // Two-flop synchroniser; resets to the idle line level so no false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_D;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Consumer handshake; a completion in the same cycle overrides below.
            if (data_valid && data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-start: glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= DATA;
                            bit_cnt  <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_M1) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt <= '0;
                        par_bad <= parity_bad(shreg, rx_s);
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == BIT_M1) begin
                        clk_cnt <= '0;
                        if (bit_cnt == STOP_M1) begin
                            // Deliver at mid-stop so the next start edge is not missed.
                            data_out   <= shreg;
                            parity_err <= par_bad;
                            frame_err  <= stop_bad | ~rx_s;
                            data_valid <= 1'b1;
                            // Same-cycle ack consumes the old word: overrun holds.
                            if (data_valid)
                                overrun <= data_ack ? overrun : 1'b1;
                            bit_cnt    <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            stop_bad <= stop_bad | ~rx_s;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Bench for uart_rx_param with three instances:
//   u0: default parameters (864 clocks/bit, 8 data, space parity, 1 stop)
//   u1: 16 clocks/bit, 8 data, space parity, 1 stop
//   u2: 16 clocks/bit, 8 data, even parity, 2 stop
// Expected words and flags come from a frame-level model of the line format.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      rx_d;
    logic [2:0]      ack;
    logic [2:0][7:0] dout;
    logic [2:0]      valid, perr, ferr, ovr, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param u0 (
        .clk(clk), .reset(reset), .Rx_D(rx_d[0]), .data_ack(ack[0]),
        .data_out(dout[0]), .data_valid(valid[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
    );

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(3), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .Rx_D(rx_d[1]), .data_ack(ack[1]),
        .data_out(dout[1]), .data_valid(valid[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
    );

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .Rx_D(rx_d[2]), .data_ack(ack[2]),
        .data_out(dout[2]), .data_valid(valid[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2])
    );

    function automatic int cpb_of(input int s);
        return (s == 0) ? 864 : 16;
    endfunction

    function automatic int mode_of(input int s);
        return (s == 2) ? 1 : 3;
    endfunction

    function automatic int nstop_of(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    // Reference: is the transmitted parity bit wrong for this line format?
    function automatic logic model_perr(input int mode, input logic [7:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        case (mode)
            1:       return (ones % 2) != 0;
            2:       return (ones % 2) == 0;
            3:       return p;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: any transmitted stop bit low is a framing error.
    function automatic logic model_ferr(input int nstop, input logic [1:0] stops);
        for (int i = 0; i < nstop; i++)
            if (!stops[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one full frame; called at a negedge, returns at a negedge with line idle.
    task automatic send_frame(input int s, input logic [7:0] d, input logic p, input logic [1:0] stops);
        int cpb;
        cpb = cpb_of(s);
        rx_d[s] = 1'b0;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_d[s] = d[i];
            repeat (cpb) @(negedge clk);
        end
        if (mode_of(s) != 0) begin
            rx_d[s] = p;
            repeat (cpb) @(negedge clk);
        end
        for (int i = 0; i < nstop_of(s); i++) begin
            rx_d[s] = stops[i];
            repeat (cpb) @(negedge clk);
        end
        rx_d[s] = 1'b1;
    endtask

    task automatic wait_valid(input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * cpb_of(s) + 10 && !ok; i++) begin
            if (valid[s]) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_ack(input int s);
        @(negedge clk) ack[s] = 1'b1;
        @(negedge clk) ack[s] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_d = 3'b111; ack = 3'b000;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({dout[s], valid[s], perr[s], ferr[s], ovr[s], busy[s]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h required 0", s,
                         {dout[s], valid[s], perr[s], ferr[s], ovr[s], busy[s]});
            end
        end
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_default_frame;
        bit ok;
        send_frame(0, 8'hA5, 1'b0, 2'b11);
        wait_valid(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL a5_valid: got 0 required 1"); end
        checks++;
        if ({dout[0], perr[0], ferr[0], ovr[0]} !== {8'hA5, 3'b000}) begin
            errors++;
            $display("FAIL a5_word: got data %h p%b f%b o%b required a5 0 0 0",
                     dout[0], perr[0], ferr[0], ovr[0]);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1) begin errors++; $display("FAIL a5_hold: valid got %b required 1", valid[0]); end
        pulse_ack(0);
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL a5_ack: valid got %b required 0", valid[0]); end
    endtask

    task automatic test_glitch;
        rx_d[0] = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b required 1", busy[0]); end
        rx_d[0] = 1'b1;
        repeat (500) @(negedge clk);
        checks++;
        if ({busy[0], valid[0], dout[0]} !== {2'b00, 8'hA5}) begin
            errors++;
            $display("FAIL glitch_reject: busy %b valid %b data %h required 0 0 a5",
                     busy[0], valid[0], dout[0]);
        end
    endtask

    task automatic test_parity;
        bit ok;
        logic p;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0);
            send_frame(2, 8'h03, p, 2'b11);
            wait_valid(2, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL parity_valid[%0d]: got 0 required 1", k); end
            checks++;
            if ({dout[2], perr[2], ferr[2]} !== {8'h03, model_perr(1, 8'h03, p), 1'b0}) begin
                errors++;
                $display("FAIL parity_word[%0d]: got data %h p%b f%b required 03 p%b f0",
                         k, dout[2], perr[2], ferr[2], model_perr(1, 8'h03, p));
            end
            pulse_ack(2);
        end
    endtask

    task automatic test_frame_err;
        bit ok;
        send_frame(1, 8'h3C, 1'b0, 2'b00);
        wait_valid(1, ok);
        checks++;
        if (!ok || {dout[1], ferr[1], perr[1]} !== {8'h3C, 2'b10}) begin
            errors++;
            $display("FAIL frame_err_set: got valid %b data %h f%b p%b required 1 3c 1 0",
                     valid[1], dout[1], ferr[1], perr[1]);
        end
        pulse_ack(1);
        repeat (32) @(negedge clk);
        send_frame(1, 8'hC3, 1'b0, 2'b11);
        wait_valid(1, ok);
        checks++;
        if (!ok || {dout[1], ferr[1]} !== {8'hC3, 1'b0}) begin
            errors++;
            $display("FAIL frame_err_clear: got valid %b data %h f%b required 1 c3 0",
                     valid[1], dout[1], ferr[1]);
        end
        pulse_ack(1);
    endtask

    task automatic test_back_to_back;
        bit ok;
        send_frame(1, 8'h11, 1'b0, 2'b11);
        send_frame(1, 8'h22, 1'b0, 2'b11);
        wait_valid(1, ok);
        checks++;
        if (!ok || {dout[1], ovr[1]} !== {8'h22, 1'b1}) begin
            errors++;
            $display("FAIL b2b_overrun: got valid %b data %h o%b required 1 22 1",
                     valid[1], dout[1], ovr[1]);
        end
        pulse_ack(1);
        checks++;
        if ({valid[1], ovr[1]} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_ack: got valid %b o%b required 0 0", valid[1], ovr[1]);
        end
        // Second pair: ack lands on the completion edge of 0x22.
        // Completion is posedge HALF + N*CPB + 3 = 8 + 160 + 3 = 171 after the fall.
        send_frame(1, 8'h11, 1'b0, 2'b11);
        fork
            send_frame(1, 8'h22, 1'b0, 2'b11);
            begin
                repeat (170) @(posedge clk);
                @(negedge clk) ack[1] = 1'b1;
                @(negedge clk) ack[1] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checks++;
        if ({valid[1], ovr[1], dout[1]} !== {2'b10, 8'h22}) begin
            errors++;
            $display("FAIL b2b_same_cycle_ack: got valid %b o%b data %h required 1 0 22",
                     valid[1], ovr[1], dout[1]);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        logic [7:0] junk;
        junk = 8'hFF;
        rx_d[1] = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_d[1] = junk[i];
            repeat (16) @(negedge clk);
        end
        rx_d[1] = junk[4];
        repeat (8) @(negedge clk);
        checks++;
        if ({busy[1], valid[1]} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_pre: got busy %b valid %b required 1 1", busy[1], valid[1]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dout[1], valid[1], perr[1], ferr[1], ovr[1], busy[1]} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_clear: got %h required 0",
                     {dout[1], valid[1], perr[1], ferr[1], ovr[1], busy[1]});
        end
        rx_d[1] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (32) @(negedge clk);
        send_frame(1, 8'h5A, 1'b0, 2'b11);
        wait_valid(1, ok);
        checks++;
        if (!ok || {dout[1], perr[1], ferr[1], ovr[1]} !== {8'h5A, 3'b000}) begin
            errors++;
            $display("FAIL midreset_next: got valid %b data %h p%b f%b o%b required 1 5a 0 0 0",
                     valid[1], dout[1], perr[1], ferr[1], ovr[1]);
        end
        pulse_ack(1);
    endtask

    task automatic test_random;
        bit ok;
        logic [7:0] d;
        logic       p;
        logic [1:0] st;
        logic       ep, ef;
        for (int n = 0; n < 20; n++) begin
            int s;
            s  = 1 + (n % 2);
            d  = 8'($urandom);
            if (mode_of(s) == 1) p = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            else                 p = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            ep = model_perr(mode_of(s), d, p);
            ef = model_ferr(nstop_of(s), st);
            send_frame(s, d, p, st);
            wait_valid(s, ok);
            checks++;
            if (!ok || {dout[s], perr[s], ferr[s], ovr[s]} !== {d, ep, ef, 1'b0}) begin
                errors++;
                $display("FAIL random[%0d] u%0d: got valid %b data %h p%b f%b o%b required 1 %h p%b f%b o0",
                         n, s, valid[s], dout[s], perr[s], ferr[s], ovr[s], d, ep, ef);
            end
            pulse_ack(s);
            repeat (2 * cpb_of(s)) @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_frame();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next generation of the SoC front-end receiver that feeds the Reed-Solomon framing FSM. Configurable bit period, data width, parity mode and stop-bit count. Adds start-bit glitch rejection, parity and framing checks, and a valid/ack output handshake with overrun detection. Sits between the `Rx_D` pad and the byte consumer (the RS input FSM).

## Interface
- `CLKS_PER_BIT`, 864, clock cycles per UART bit (≥4); 864 at 100 MHz gives the existing 8640 ns bit period.
- `DATA_BITS`, 8, data bits per frame (5..9), LSB first.
- `PARITY_MODE`, 3, 0 = none, 1 = even, 2 = odd, 3 = space (parity bit must be 0; current link format).
- `STOP_BITS`, 1, 1 or 2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `Rx_D` in 1: serial line, idle high, asynchronous to `clk`.
- `data_ack` in 1: consumer accepts `data_out`; only meaningful while `data_valid`=1.
- `data_out` out DATA_BITS: last received word.
- `data_valid` out 1: word available; held until acknowledged.
- `parity_err` out 1: parity check failed for the word in `data_out` (always 0 when PARITY_MODE=0).
- `frame_err` out 1: at least one stop bit of that word sampled 0.
- `overrun` out 1: a word was overwritten before being acknowledged.
- `busy` out 1: a frame is being received (state ≠ IDLE).

## Operation
- `Rx_D` passes through a 2-FF synchroniser (`rx_s`). Both FFs reset to 1.
- Counters: `clk_cnt` [$clog2(CLKS_PER_BIT)] and `bit_cnt` [$clog2(DATA_BITS+1)]. Shift register `shreg` [DATA_BITS], filled LSB first (right-shift in at MSB).
- HALF = CLKS_PER_BIT/2 (integer division).
- States:
  - IDLE: if `rx_s`=0, go to START with `clk_cnt`=0.
  - START: when `clk_cnt`=HALF-1, sample. If `rx_s`=1 (glitch), return to IDLE with no output change. Otherwise go to DATA with `clk_cnt`=0 and `bit_cnt`=0.
  - DATA: sample when `clk_cnt`=CLKS_PER_BIT-1, then clear `clk_cnt`. After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: one sample. Error if: even mode and XOR(data, p)=1; odd mode and XOR(data, p)=0; space mode and p=1.
  - STOP: STOP_BITS samples; any 0 sets the frame error.
- On the last stop sample: load `data_out`, `parity_err`, `frame_err`; set `data_valid`=1; go to IDLE in the same cycle. This allows the next start edge to be detected from mid-stop-bit onward.
- Words with parity or framing errors are still delivered, with their flags set.
- Handshake:
  - `data_valid` clears on the cycle after `data_ack`=1 while valid.
  - A completion while `data_valid`=1 and no ack overwrites `data_out`, keeps valid=1 and sets `overrun`=1.
  - `overrun` clears together with `data_valid` on ack.
  - Completion and ack in the same cycle: the old word is consumed, the new word is loaded, `data_valid` stays 1 and `overrun` does not change.
- `data_ack` while `data_valid`=0 is ignored.

## Timing
- Reset values:
  - `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - State IDLE, counters 0, `shreg`=0, synchroniser = 1.
- Reset mid-frame aborts immediately. After release the block waits in IDLE for `rx_s`=0; a partially received line is treated as a new frame only at the next falling level.
- Let c = the cycle in IDLE where `rx_s`=0 is seen, which is 2 cycles after `Rx_D` falls. Let N = DATA_BITS + (PARITY_MODE≠0) + STOP_BITS.
  - Start sample at c+HALF.
  - Sample k (k=1..N) at c+HALF+k·CLKS_PER_BIT.
  - `data_valid` rises at c+HALF+N·CLKS_PER_BIT+1.
- `busy` is high from c+1 through the last stop-sample cycle.
- All outputs are registered; there is no combinational path from `Rx_D` or `data_ack` to any output.

## Test plan
- Defaults, frame 0xA5, parity 0, stop 1, bit time 8640 ns → `data_out`=0xA5 and `data_valid`=1, all flags 0. Hold `data_ack`=0: valid stays 1. Pulse ack: valid 0 the next cycle.
- PARITY_MODE=1, byte 0x03 with parity bit 1 → `parity_err`=1, `data_out`=0x03. Repeat with parity bit 0 → `parity_err`=0.
- Defaults, byte 0x3C with stop bit 0 → `frame_err`=1, `data_out`=0x3C. The next frame with a good stop bit clears `frame_err`.
- Drive `Rx_D` low for 200 cycles, then high (CLKS_PER_BIT=864) → `busy` pulses, then returns to 0. No `data_valid`; `data_out` is unchanged.
- Two back-to-back frames 0x11 then 0x22, no ack → `data_out`=0x22, `overrun`=1. Ack → `data_valid`=0 and `overrun`=0. Repeat with ack asserted in the completion cycle of 0x22 → `overrun` stays 0 and valid stays 1.
- Assert `reset` mid-data-bit 4 → all outputs 0 within one clock edge. The following clean frame 0x5A is received correctly.
